imem_loader: RTL and testbench

- Boot-time writer for the instruction memory; the counterpart to the datapath, which only reads instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word to consecutive word addresses from 0 and holds the CPU in reset until the image loads and verifies.
- Sits between the host link (UART/JTAG byte source) and the instruction-memory write port.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Receives a framed byte stream (MAGIC, LEN_HI, LEN_LO, LEN*4 payload bytes, CSUM),
// assembles big-endian 32-bit words and writes them to consecutive word addresses
// from 0. The CPU is held in reset until the whole image is written and the XOR
// checksum matches.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   restart_i      one-cycle pulse, re-arms the loader from DONE or ERROR
//   in_valid_i     byte-source data valid
//   in_data_i      byte-source data
//   in_ready_o     loader can accept a byte
//   wr_en_o        instruction-memory write strobe, one cycle per word
//   wr_addr_o      word address of the write
//   wr_data_o      instruction word
//   cpu_reset_o    active-high hold for the datapath reset
//   done_o         image loaded and checksum matched
//   error_o        frame rejected, sticky until restart or reset
//   word_count_o   words written in the current frame
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              restart_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o,
  output logic [15:0]       word_count_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StCsum  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StError = 3'd6;

  // 17 bits so a full 16-bit LEN can be compared without overflow
  localparam logic [16:0] MaxLen = 17'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;   // words assembled so far (next address)
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       shift_q, shift_d;         // first three bytes of the current word
  logic [7:0]        csum_q, csum_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [15:0]       word_count_q, word_count_d;

  logic        ready;
  logic        accept;
  logic [15:0] len_full;

  // Ready is forced low while reset is being sampled
  assign ready  = rst_ni && (state_q != StDone) && (state_q != StError);
  assign accept = in_valid_i && ready;
  assign len_full = {len_q[15:8], in_data_i};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;

    if (wr_en_q) begin
      word_count_d = word_count_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (accept && (in_data_i == MAGIC)) begin
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d   = {in_data_i, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > MaxLen) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_idx_q[ADDR_W-1:0];
            wr_data_d  = {shift_q, in_data_i};
            word_idx_d = word_idx_q + 16'd1;
            if ((word_idx_q + 16'd1) == len_q) begin
              state_d = StCsum;
            end
          end else begin
            shift_d = {shift_q[15:0], in_data_i};
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (in_data_i == csum_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        if (restart_i) begin
          state_d      = StIdle;
          word_count_d = 16'd0;
          csum_d       = 8'h00;
          byte_idx_d   = 2'd0;
          word_idx_d   = 16'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      len_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_idx_q   <= 2'd0;
      shift_q      <= 24'd0;
      csum_q       <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready_o   = ready;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cpu_reset_o  = (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign error_o      = (state_q == StError);
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames,
// compared against a frame-parsing reference model.
module tb_imem_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1024;
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [15:0]   word_count;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W    (AW),
    .MAX_WORDS (MAXW),
    .MAGIC     (MAGIC)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .restart_i    (restart),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .cpu_reset_o  (cpu_reset),
    .done_o       (done),
    .error_o      (error),
    .word_count_o (word_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Write monitor
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic          prev_wr = 1'b0;

  always @(negedge clk) begin
    if (rst_n && wr_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      check_eq("wr_en_one_cycle", 32'(prev_wr), 32'd0);
    end
    prev_wr = wr_en;
  end

  // Reference model: parse the frame from its rules
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_err;

  task automatic model(input byte_q_t fr);
    int i = 0;
    int len;
    logic [7:0] x = 8'h00;
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (i < fr.size() && fr[i] != MAGIC) i++;
    len = 256 * int'(fr[i+1]) + int'(fr[i+2]);
    i += 3;
    if (len > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < len; w++) begin
      exp_data.push_back({fr[i], fr[i+1], fr[i+2], fr[i+3]});
      x = x ^ fr[i] ^ fr[i+1] ^ fr[i+2] ^ fr[i+3];
      i += 4;
    end
    if (fr[i] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ":done"}, 32'(done), 32'd0);
    check_eq({tag, ":error"}, 32'(error), 32'd0);
    check_eq({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, ":cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, ":word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ":in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, ":wr_en"}, 32'(wr_en), 32'd0);
    check_eq({tag, ":wr_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, ":wr_data"}, wr_data, 32'd0);
    check_eq({tag, ":cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, ":done"}, 32'(done), 32'd0);
    check_eq({tag, ":error"}, 32'(error), 32'd0);
    check_eq({tag, ":word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic pulse_restart(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    check_idle({tag, ":restart"});
  endtask

  task automatic run_frame(input string name, input byte_q_t fr, input int gap, input bit rnd_gap);
    got_addr.delete();
    got_data.delete();
    model(fr);
    foreach (fr[i]) send_byte(fr[i], rnd_gap ? int'($urandom_range(0, 3)) : gap);
    repeat (3) @(negedge clk);
    check_eq({name, ":nwrites"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check_eq({name, ":addr"}, 32'(got_addr[i]), 32'(i % (1 << AW)));
      check_eq({name, ":data"}, got_data[i], exp_data[i]);
    end
    check_eq({name, ":done"}, 32'(done), 32'(exp_done));
    check_eq({name, ":error"}, 32'(error), 32'(exp_err));
    check_eq({name, ":cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check_eq({name, ":in_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, ":word_count"}, 32'(word_count), 32'(exp_data.size()));
    pulse_restart(name);
  endtask

  byte_q_t basic;
  byte_q_t fr;

  initial begin
    // Payload XOR of 3C 08 00 05 20 09 00 07 is 0x1F
    basic = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h05,
              8'h20, 8'h09, 8'h00, 8'h07, 8'h1F};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    run_frame("basic", basic, 0, 1'b0);

    fr = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("noise_zero_len", fr, 0, 1'b0);

    fr = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    run_frame("bad_csum", fr, 0, 1'b0);

    fr = '{8'hA5, 8'h04, 8'h01};
    run_frame("oversize", fr, 0, 1'b0);

    run_frame("throttled", basic, 3, 1'b0);

    // Largest legal image covers the last word address
    fr = '{8'hA5, 8'h04, 8'h00};
    begin
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      for (int i = 0; i < 4 * MAXW; i++) begin
        b = 8'($urandom);
        x ^= b;
        fr.push_back(b);
      end
      fr.push_back(x);
    end
    run_frame("max_len", fr, 0, 1'b0);

    // Reset after two bytes of word 1
    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < 9; i++) send_byte(basic[i], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_word_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_word_release");
    repeat (6) @(negedge clk);
    check_eq("mid_word_nwrites", 32'(got_data.size()), 32'd1);
    run_frame("after_reset", basic, 0, 1'b0);

    // Randomized frames: noise prefix, random length, occasional corruption
    for (int t = 0; t < 25; t++) begin
      int kind;
      int len;
      logic [7:0] x;
      logic [7:0] b;
      fr.delete();
      for (int n = int'($urandom_range(0, 2)); n > 0; n--) begin
        b = 8'($urandom);
        if (b == MAGIC) b = 8'h5A;
        fr.push_back(b);
      end
      fr.push_back(MAGIC);
      kind = int'($urandom_range(0, 9));
      len  = (kind == 0) ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(0, 6));
      fr.push_back(8'(len >> 8));
      fr.push_back(8'(len));
      if (kind != 0) begin
        x = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
          b = 8'($urandom);
          x ^= b;
          fr.push_back(b);
        end
        if (kind == 1) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      run_frame("random", fr, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
